// File: rtl/data_mem_responder_pkg.sv
// Shared constants and helpers for the data memory responder: FSM encoding,
// access-size encoding, default geometry/timing and the fault predicate.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic {
        SZ_WORD = 1'b0,
        SZ_HALF = 1'b1
    } access_size_t;

    localparam int unsigned DMEM_DEPTH_BYTES_DEF = 128;
    localparam int unsigned DMEM_WAIT_CYCLES_DEF = 2;

    // 33-bit last-byte sum so that a wrap past 0xFFFFFFFF reads as out of range
    function automatic logic access_fault(input logic [31:0]  addr,
                                          input access_size_t size,
                                          input logic [32:0]  depth);
        logic [32:0] last;
        logic        misaligned;
        last       = {1'b0, addr} + ((size == SZ_WORD) ? 33'd3 : 33'd1);
        misaligned = (size == SZ_WORD) ? (addr[1:0] != 2'b00) : addr[0];
        return misaligned || (last >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control unit (master) and the data
// memory responder (slave).
interface data_mem_responder_if;
    logic        req;
    logic        mWR;
    logic        getHW;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (output req, mWR, getHW, addr, wdata,
                    input  ready, rdata, err, busy);
    modport slave  (input  req, mWR, getHW, addr, wdata,
                    output ready, rdata, err, busy);
endinterface

// File: rtl/data_mem_responder_byte_array.sv
// Word-organised storage split into four byte lanes; lane 0 holds the lowest
// byte address of each word (bits [31:24]). One write port, async read.
module dmem_byte_array #(
    parameter int unsigned WORDS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] r_lane [WORDS];

        always_ff @(posedge clk) begin
            if (i_we[lane]) begin
                r_lane[i_waddr] <= i_wdata[31-8*lane -: 8];
            end
        end

        assign o_rdata[31-8*lane -: 8] = r_lane[i_raddr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, answers with a
// one-cycle ready pulse. Define DMEM_WAIT_EN to add WAIT_CYCLES access cycles.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DMEM_DEPTH_BYTES_DEF,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW+1:0] r_addr;
    logic          r_wr;
    access_size_t  r_size;
    logic          r_fault;

    access_size_t  w_size_in;
    logic          w_fault_in;
    logic          w_accept;
    logic          w_wait_done;
    logic          w_commit_idle;
    logic          w_commit_wait;
    logic [3:0]    w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rword;
    logic          w_done;

    assign w_size_in  = (bus.mWR || !bus.getHW) ? SZ_WORD : SZ_HALF;
    assign w_fault_in = access_fault(bus.addr, w_size_in, 33'(DEPTH_BYTES));
    assign w_accept   = (r_state == ST_IDLE) && bus.req;
    assign w_done     = (r_state == ST_DONE);

`ifdef DMEM_WAIT_EN
    localparam bit USE_WAIT = (WAIT_CYCLES > 0);

    logic [3:0]  r_wait_cnt;
    logic [31:0] r_wdata;

    assign w_wait_done   = (r_wait_cnt == 4'd0);
    assign w_commit_wait = (r_state == ST_WAIT) && w_wait_done && r_wr && !r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
            r_wdata    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_wdata <= bus.wdata;
            end
            if (w_accept && USE_WAIT) begin
                r_wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else if ((r_state == ST_WAIT) && !w_wait_done) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end
`else
    localparam bit USE_WAIT = 1'b0;

    logic [31:0] r_wdata;

    assign w_wait_done   = 1'b1;
    assign w_commit_wait = 1'b0;
    assign r_wdata       = 32'd0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.req) w_state_nxt = USE_WAIT ? ST_WAIT : ST_DONE;
`ifdef DMEM_WAIT_EN
            ST_WAIT: if (w_wait_done) w_state_nxt = ST_DONE;
`endif
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Without wait cycles the store lands on the accept edge itself, straight from the bus.
    assign w_commit_idle = w_accept && !USE_WAIT && bus.mWR && !w_fault_in;
    assign w_we          = {4{!reset && (w_commit_idle || w_commit_wait)}};
    assign w_waddr       = w_commit_idle ? bus.addr[AW+1:2] : r_addr[AW+1:2];
    assign w_wdata       = w_commit_idle ? bus.wdata : r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_size  <= SZ_WORD;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= bus.addr[AW+1:0];
                r_wr    <= bus.mWR;
                r_size  <= w_size_in;
                r_fault <= w_fault_in;
            end
        end
    end

    dmem_byte_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_addr[AW+1:2]),
        .o_rdata (w_rword)
    );

    always_comb begin
        bus.rdata = 32'd0;
        if (w_done && !r_wr && !r_fault) begin
            if (r_size == SZ_HALF) begin
                bus.rdata = {16'd0, (r_addr[1] ? w_rword[15:0] : w_rword[31:16])};
            end else begin
                bus.rdata = w_rword;
            end
        end
    end

    assign bus.ready = w_done;
    assign bus.err   = w_done && r_fault;
    assign bus.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand-built corner sequences and
// random traffic against a byte-addressed reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 128;
    localparam int WAITC = 3;
`ifdef DMEM_WAIT_EN
    localparam int LAT = 1 + WAITC;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset;
    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_BYTES (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] m_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-granular big-endian memory, plain arithmetic on a 64-bit address.
    task automatic model_access(input bit wr, input bit hw, input logic [31:0] a,
                                input logic [31:0] wd,
                                output logic [31:0] rd, output bit e);
        longint unsigned size;
        longint unsigned last;
        size = wr ? 4 : (hw ? 2 : 4);
        last = longint'({32'd0, a}) + size - 1;
        e    = ((longint'({32'd0, a}) % size) != 0) || (last >= DEPTH);
        rd   = 32'd0;
        if (!e) begin
            for (int i = 0; i < int'(size); i++) begin
                if (wr) m_mem[int'(a) + i] = wd[8*(3-i) +: 8];
                else    rd = (rd << 8) | 32'(m_mem[int'(a) + i]);
            end
        end
    endtask

    task automatic run_access(input bit wr, input bit hw, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic e, output int lat, output bit busy_low);
        @(negedge clk);
        bus.req = 1'b1; bus.mWR = wr; bus.getHW = hw; bus.addr = a; bus.wdata = wd;
        @(negedge clk);
        bus.req = 1'b0; bus.addr = $urandom; bus.wdata = $urandom;
        bus.mWR = 1'($urandom); bus.getHW = 1'($urandom);
        lat = 1;
        busy_low = 1'b0;
        while (!bus.ready && lat < 50) begin
            if (!bus.busy) busy_low = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!bus.busy) busy_low = 1'b1;
        if (!bus.ready) lat = -1;
        rd = bus.rdata;
        e  = bus.err;
    endtask

    task automatic check_access(input string name, input bit wr, input bit hw,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input bit exp_e);
        logic [31:0] rd;
        logic        e;
        int          lat;
        bit          busy_low;
        run_access(wr, hw, a, wd, rd, e, lat, busy_low);
        chk({name, "_lat"},   32'(lat), 32'(LAT));
        chk({name, "_busy"},  32'(busy_low), 32'd0);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"},   32'(e), 32'(exp_e));
        @(negedge clk);
        chk({name, "_after"}, {bus.rdata[30:0] | 31'(bus.ready), bus.busy}, 32'd0);
    endtask

    task automatic model_check(input string name, input bit wr, input bit hw,
                               input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] erd;
        bit          ee;
        model_access(wr, hw, a, wd, erd, ee);
        check_access(name, wr, hw, a, wd, erd, ee);
    endtask

    typedef struct {
        bit          wr;
        bit          hw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_e;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] drd;
        bit          de;
        bit          seen_ready;
        int          guard;

        tbl[0]  = '{1'b1, 1'b0, 32'h10,       32'h12345678, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        32'h12345678, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h12,       32'h0,        32'h00005678, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h10,       32'h0,        32'h00001234, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h11,       32'h0,        32'h0,        1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h13,       32'h0,        32'h0,        1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'h7C,       32'hCAFEF00D, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h7E,       32'h11111111, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 1'b0, 32'h7C,       32'h0,        32'hCAFEF00D, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h7E,       32'h0,        32'h0000F00D, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h80,       32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b0, 1'b1, 32'hFFFFFFFE, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b0, 1'b0, 32'h7D,       32'h0,        32'h0,        1'b1};
        tbl[14] = '{1'b1, 1'b1, 32'h20,       32'h0BADF00D, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 1'b0, 32'h20,       32'h0,        32'h0BADF00D, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 32'h7F,       32'h0,        32'h0,        1'b1};

        reset = 1'b1;
        bus.req = 1'b0; bus.mWR = 1'b0; bus.getHW = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.rdata[29:0] , bus.ready | bus.err, bus.busy}, 32'd0);
        reset = 1'b0;

        // Give every word a known value so random loads have a defined answer.
        for (int w = 0; w < DEPTH / 4; w++) begin
            model_check("init", 1'b1, 1'b0, 32'(w * 4), $urandom);
        end

        for (int i = 0; i < 17; i++) begin
            check_access($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].hw, tbl[i].addr,
                         tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_e);
            model_access(tbl[i].wr, tbl[i].hw, tbl[i].addr, tbl[i].wdata, drd, de);
        end

        // req held high with a different store while busy: it must be ignored.
        model_access(1'b0, 1'b0, 32'h40, 32'h0, drd, de);
        @(negedge clk);
        bus.req = 1'b1; bus.mWR = 1'b0; bus.getHW = 1'b0; bus.addr = 32'h40;
        @(negedge clk);
        bus.mWR = 1'b1; bus.addr = 32'h44; bus.wdata = 32'hA5A5A5A5;
        guard = 1;
        while (!bus.ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("busyreq_lat", 32'(guard), 32'(LAT));
        chk("busyreq_rdata", bus.rdata, drd);
        bus.req = 1'b0;
        @(negedge clk);
        chk("busyreq_idle", {30'd0, bus.ready, bus.busy}, 32'd0);
        model_check("busyreq_44", 1'b0, 1'b0, 32'h44, 32'h0);

        // reset and req together: request is dropped.
        @(negedge clk);
        reset = 1'b1;
        bus.req = 1'b1; bus.mWR = 1'b1; bus.addr = 32'h48; bus.wdata = 32'h0F0F0F0F;
        @(negedge clk);
        reset = 1'b0; bus.req = 1'b0;
        seen_ready = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            if (bus.ready || bus.busy) seen_ready = 1'b1;
            @(negedge clk);
        end
        chk("rstreq_no_ready", 32'(seen_ready), 32'd0);
        model_check("rstreq_48", 1'b0, 1'b0, 32'h48, 32'h0);

`ifdef DMEM_WAIT_EN
        // reset in the 2nd wait cycle of a store aborts it.
        @(negedge clk);
        bus.req = 1'b1; bus.mWR = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.req = 1'b0;
        chk("rstwait_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstwait_idle", {29'd0, bus.ready, bus.err, bus.busy}, 32'd0);
        repeat (LAT) @(negedge clk);
        model_check("rstwait_20", 1'b0, 1'b0, 32'h20, 32'h0);
`else
        // reset in the ready cycle clears every output on the next edge.
        @(negedge clk);
        bus.req = 1'b1; bus.mWR = 1'b0; bus.getHW = 1'b0; bus.addr = 32'h20;
        @(negedge clk);
        bus.req = 1'b0;
        chk("rstdone_ready", 32'(bus.ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstdone_idle", {bus.rdata[28:0], bus.ready, bus.err, bus.busy}, 32'd0);
        model_check("rstdone_20", 1'b0, 1'b0, 32'h20, 32'h0);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 7);
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = 32'($urandom_range(32'h7A, 32'h83));
            else               a = 32'($urandom_range(0, DEPTH - 1));
            model_check($sformatf("rnd%0d", i), ($urandom_range(0, 2) == 0),
                        1'($urandom), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
